// File: rtl/stepper_seq_if.sv
// -----------------------------------------------------------------------------
// stepper_seq_if
//   Bundles the control inputs and step outputs of stepper_seq.
//
//   Optional feature macro: STEPPER_SEQ_LEN_EN (adds step_len).
//
//   Signals:
//     en        advance enable (0 = stall on current step)
//     restart   end current instruction early, return to step 0
//     halt_req  level request to halt at the next instruction boundary
//     resume    pulse that leaves HALTED
//     step_len  runtime instruction length (STEPPER_SEQ_LEN_EN only)
//     step      one-hot current step, all zero while HALTED
//     step_idx  binary index of current step, 0 while HALTED
//     last      current step is the effective last step (RUN only)
//     boundary  one-cycle pulse when step 0 / HALTED is entered by wrap/restart
//     halted    sequencer is in HALTED
//
//   Modports: master drives the controls, slave is the sequencer itself.
// -----------------------------------------------------------------------------
interface stepper_seq_if #(
    parameter int NUM_STEPS = 6,
    parameter int IDX_W     = $clog2(NUM_STEPS)
);
    logic                 en;
    logic                 restart;
    logic                 halt_req;
    logic                 resume;
`ifdef STEPPER_SEQ_LEN_EN
    logic [IDX_W:0]       step_len;
`endif
    logic [NUM_STEPS-1:0] step;
    logic [IDX_W-1:0]     step_idx;
    logic                 last;
    logic                 boundary;
    logic                 halted;

    modport master (
`ifdef STEPPER_SEQ_LEN_EN
        output step_len,
`endif
        output en,
        output restart,
        output halt_req,
        output resume,
        input  step,
        input  step_idx,
        input  last,
        input  boundary,
        input  halted
    );

    modport slave (
`ifdef STEPPER_SEQ_LEN_EN
        input  step_len,
`endif
        input  en,
        input  restart,
        input  halt_req,
        input  resume,
        output step,
        output step_idx,
        output last,
        output boundary,
        output halted
    );
endinterface

// File: rtl/stepper_seq.sv
// -----------------------------------------------------------------------------
// stepper_seq
//   Parametrised instruction step sequencer for the CPU control path.
//   Produces a one-hot step vector plus its binary index, advancing on en,
//   jumping back to step 0 on restart or after the last step (wrap), and
//   parking in HALTED when halt_req is seen at an instruction boundary.
//   All outputs come straight from registers.
//
//   Optional feature macro: STEPPER_SEQ_LEN_EN
//     Adds bus.step_len, a runtime instruction length sampled on every
//     entry to step 0. Length 0 or > NUM_STEPS means NUM_STEPS.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   stepper_seq_if.slave (controls in, step state out)
// -----------------------------------------------------------------------------
module stepper_seq #(
    parameter int NUM_STEPS = 6,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic         clk,
    input  logic         rst,
    stepper_seq_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]     MAX_LAST = IDX_W'(NUM_STEPS - 1);
    localparam logic [NUM_STEPS-1:0] STEP0    = NUM_STEPS'(1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_STEPS-1:0] r_step;
    logic                 r_last;
    logic                 r_boundary;
    logic                 r_halted;

    // Effective last step of the instruction currently executing, and of
    // the instruction that would start if step 0 were entered this edge.
    logic [IDX_W-1:0]     w_cur_last;
    logic [IDX_W-1:0]     w_entry_last;
    logic                 w_wrap;
    logic                 w_bnd_event;

`ifdef STEPPER_SEQ_LEN_EN
    logic [IDX_W-1:0]     r_len_last;
    logic                 w_enter_step0;

    // Map a requested length onto the index of its last step.
    function automatic logic [IDX_W-1:0] len_to_last(input logic [IDX_W:0] len);
        if ((len == '0) || (len > (IDX_W+1)'(NUM_STEPS)))
            return MAX_LAST;
        else
            return IDX_W'(len - (IDX_W+1)'(1));
    endfunction

    assign w_entry_last = len_to_last(bus.step_len);
    assign w_cur_last   = r_len_last;

    // Every path into step 0 except reset: restart/wrap without halting,
    // or resume out of HALTED.
    assign w_enter_step0 = ((r_state == ST_RUN) && w_bnd_event && !bus.halt_req) ||
                           ((r_state == ST_HALTED) && bus.resume);

    always_ff @(posedge clk) begin
        if (rst)
            r_len_last <= MAX_LAST;
        else if (w_enter_step0)
            r_len_last <= w_entry_last;
    end
`else
    assign w_entry_last = MAX_LAST;
    assign w_cur_last   = MAX_LAST;
`endif

    assign w_wrap      = bus.en && (r_idx == w_cur_last);
    assign w_bnd_event = bus.restart || w_wrap;

    // Single FSM: every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_idx      <= '0;
            r_step     <= STEP0;
            r_last     <= 1'b0;
            r_boundary <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_bnd_event) begin
                        // Instruction boundary: restart beats en, and a
                        // pending halt request diverts to HALTED instead of
                        // starting the next instruction.
                        r_idx      <= '0;
                        r_boundary <= 1'b1;
                        if (bus.halt_req) begin
                            r_state  <= ST_HALTED;
                            r_step   <= '0;
                            r_last   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_step <= STEP0;
                            // A length-1 instruction is already on its last step.
                            r_last <= (w_entry_last == '0);
                        end
                    end else if (bus.en) begin
                        r_idx      <= r_idx + IDX_W'(1);
                        r_step     <= {r_step[NUM_STEPS-2:0], 1'b0};
                        r_last     <= ((r_idx + IDX_W'(1)) == w_cur_last);
                        r_boundary <= 1'b0;
                    end else begin
                        r_boundary <= 1'b0;
                    end
                end

                ST_HALTED: begin
                    // Frozen except for the boundary pulse dropping and resume.
                    r_boundary <= 1'b0;
                    if (bus.resume) begin
                        r_state  <= ST_RUN;
                        r_idx    <= '0;
                        r_step   <= STEP0;
                        r_last   <= (w_entry_last == '0);
                        r_halted <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.step     = r_step;
    assign bus.step_idx = r_idx;
    assign bus.last     = r_last;
    assign bus.boundary = r_boundary;
    assign bus.halted   = r_halted;

endmodule

// File: tb/tb_stepper_seq.sv
// -----------------------------------------------------------------------------
// tb_stepper_seq
//   Directed, table-driven bench for stepper_seq with NUM_STEPS = 6.
//   Each table row gives the inputs applied before a rising edge and the
//   outputs expected just after it. A free-running sequence follows.
// -----------------------------------------------------------------------------
module tb_stepper_seq;

    localparam int NS = 6;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stepper_seq_if #(.NUM_STEPS(NS)) bus ();

    stepper_seq #(.NUM_STEPS(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic          rs;
        logic          hr;
        logic          rsm;
        logic [IW:0]   len;
        logic [IW-1:0] idx;
        logic [NS-1:0] step;
        logic          last;
        logic          bnd;
        logic          hlt;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst_i, input logic en_i, input logic rs_i,
                       input logic hr_i, input logic rsm_i, input logic [IW:0] len_i,
                       input logic [IW-1:0] idx_i, input logic [NS-1:0] st_i,
                       input logic l_i, input logic b_i, input logic h_i);
        vec_t v;
        v.rst = rst_i; v.en = en_i; v.rs = rs_i; v.hr = hr_i; v.rsm = rsm_i;
        v.len = len_i; v.idx = idx_i; v.step = st_i; v.last = l_i;
        v.bnd = b_i; v.hlt = h_i;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst_i, input logic en_i, input logic rs_i,
                         input logic hr_i, input logic rsm_i, input logic [IW:0] len_i);
        @(negedge clk);
        rst          = rst_i;
        bus.en       = en_i;
        bus.restart  = rs_i;
        bus.halt_req = hr_i;
        bus.resume   = rsm_i;
`ifdef STEPPER_SEQ_LEN_EN
        bus.step_len = len_i;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int n,
                         input logic [IW+NS+2:0] act, input logic [IW+NS+2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got idx/step/last/bnd/hlt=%b want %b", name, n, act, exp);
        end
    endtask

    int m;

    initial begin
        bus.en = 1'b0; bus.restart = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
`ifdef STEPPER_SEQ_LEN_EN
        bus.step_len = '0;
`endif
        //   rst en rs hr rsm len  idx  step      last bnd hlt
        // reset, then free run through one wrap
        add(1, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 3, 6'b001000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 4, 6'b010000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 5, 6'b100000, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 6'b000001, 0, 1, 0);
        // stall at step 2
        add(0, 1, 0, 0, 0, 0, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 3, 6'b001000, 0, 0, 0);
        // restart beats en at step 3; boundary lasts one cycle
        add(0, 1, 1, 0, 0, 0, 0, 6'b000001, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
        // restart at step 0
        add(0, 0, 1, 0, 0, 0, 0, 6'b000001, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 6'b000010, 0, 0, 0);
        // halt_req from step 1 through the wrap
        add(0, 1, 0, 1, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 3, 6'b001000, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 4, 6'b010000, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 5, 6'b100000, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 6'b000000, 0, 1, 1);
        // HALTED ignores en/restart/halt_req
        add(0, 1, 1, 1, 0, 0, 0, 6'b000000, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0, 6'b000000, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 6'b000001, 0, 0, 0);
        // resume in RUN does nothing
        add(0, 1, 0, 0, 1, 0, 1, 6'b000010, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 6'b000010, 0, 0, 0);
        // halt via restart, then resume
        add(0, 0, 1, 1, 0, 0, 0, 6'b000000, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 6'b000001, 0, 0, 0);
        // reset mid-instruction dominates en and restart
        add(0, 1, 0, 0, 0, 0, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 3, 6'b001000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 4, 6'b010000, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
        // reset out of HALTED
        add(0, 0, 1, 1, 0, 0, 0, 6'b000000, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
`ifdef STEPPER_SEQ_LEN_EN
        // length 3 loaded on restart
        add(0, 0, 1, 0, 0, 3, 0, 6'b000001, 0, 1, 0);
        add(0, 1, 0, 0, 0, 3, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 3, 2, 6'b000100, 1, 0, 0);
        add(0, 1, 0, 0, 0, 3, 0, 6'b000001, 0, 1, 0);
        // length 5 presented mid-instruction: current one still ends at 2
        add(0, 1, 0, 0, 0, 5, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 5, 2, 6'b000100, 1, 0, 0);
        add(0, 1, 0, 0, 0, 5, 0, 6'b000001, 0, 1, 0);
        add(0, 1, 0, 0, 0, 5, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 5, 2, 6'b000100, 0, 0, 0);
        add(0, 1, 0, 0, 0, 5, 3, 6'b001000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 5, 4, 6'b010000, 1, 0, 0);
        add(0, 1, 0, 0, 0, 5, 0, 6'b000001, 0, 1, 0);
        // length 0 means full length 6
        add(0, 0, 1, 0, 0, 0, 0, 6'b000001, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 6'b000010, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 2, 6'b000100, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 3, 6'b001000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 4, 6'b010000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 5, 6'b100000, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 6'b000001, 0, 1, 0);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].en, vq[i].rs, vq[i].hr, vq[i].rsm, vq[i].len);
            check("vec", i,
                  {bus.step_idx, bus.step, bus.last, bus.boundary, bus.halted},
                  {vq[i].idx, vq[i].step, vq[i].last, vq[i].bnd, vq[i].hlt});
        end

        // Free run over three instructions against a modulo-6 counter model.
        drive(1, 0, 0, 0, 0, 0);
        m = 0;
        for (int k = 0; k < 18; k++) begin
            logic [NS-1:0] exp_step;
            drive(0, 1, 0, 0, 0, 0);
            m = (m + 1) % NS;
            exp_step = '0;
            exp_step[m] = 1'b1;
            check("run", k,
                  {bus.step_idx, bus.step, bus.last, bus.boundary, bus.halted},
                  {IW'(m), exp_step, (m == NS - 1), (m == 0), 1'b0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
